// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential divider
//
// Purpose: state encoding, default operand width and the divide-by-zero
// quotient pattern used by seq_divider and div_step.
// Ports: none (package).
package div_pkg;

   localparam int DIV_N = 32;

   // Divide-by-zero quotient: all ones.
   localparam logic [DIV_N-1:0] DIV_ZERO_Q = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FIXUP = 2'd2,
      DONE  = 2'd3
   } div_state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-divide trial subtract (parallel-prefix carry lookahead)
//
// Purpose: diff = minuend - subtrahend, computed as minuend + ~subtrahend + 1
// with the carries produced by a Kogge-Stone prefix tree.
// Ports:
//   minuend    in  W  shifted partial remainder
//   subtrahend in  W  zero-extended divisor magnitude
//   diff       out W  minuend - subtrahend (mod 2^W)
//   no_borrow  out 1  1 when minuend >= subtrahend (carry out of the add)
module div_step
   import div_pkg::*;
#(
   parameter int W = DIV_N + 1
) (
   input  logic [W-1:0] minuend,
   input  logic [W-1:0] subtrahend,
   output logic [W-1:0] diff,
   output logic         no_borrow
);

   logic [W-1:0] b_inv;
   logic [W-1:0] gen;
   logic [W-1:0] prop;
   logic [W-1:0] gk;
   logic [W-1:0] pk;
   logic [W:0]   carry;

   assign b_inv = ~subtrahend;

   always_comb begin
      gen  = minuend & b_inv;
      prop = minuend ^ b_inv;
      gk   = gen;
      pk   = prop;
      // Descending index so gk[i-d]/pk[i-d] still hold the previous level.
      for (int d = 1; d < W; d = d * 2) begin
         for (int i = W - 1; i >= d; i--) begin
            gk[i] = gk[i] | (pk[i] & gk[i-d]);
            pk[i] = pk[i] & pk[i-d];
         end
      end
      // Carry-in is 1 (two's-complement subtract), so every group that
      // propagates also produces a carry.
      carry     = {gk | pk, 1'b1};
      diff      = prop ^ carry[W-1:0];
      no_borrow = carry[W];
   end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring divider for DIV/DIVU (HI/LO results)
//
// Purpose: shift-and-subtract divide, one quotient bit per cycle, under a
// start/busy/done handshake. Signed support is compiled in only when the
// macro SEQ_DIVIDER_SIGNED_EN is defined; otherwise every divide is unsigned.
// Ports:
//   clk         in  1  system clock, rising edge
//   rst         in  1  asynchronous active-high reset
//   start       in  1  request, sampled in IDLE or DONE
//   is_signed   in  1  two's-complement divide when 1
//   dividend    in  N  numerator
//   divisor     in  N  denominator
//   busy        out 1  division in progress
//   done        out 1  one-cycle pulse, results valid from here on
//   quotient    out N  quotient (LO)
//   remainder   out N  remainder (HI)
//   div_by_zero out 1  divisor was zero, held until the next start
module seq_divider
   import div_pkg::*;
#(
   parameter int N = DIV_N
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         is_signed,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;

   div_state_t    state;
   div_state_t    state_nxt;
   logic          accept;
   logic [CW-1:0] cnt;
   logic          last_iter;
   logic          dvs_zero;

   // Partial remainder is always below the divisor after an iteration, so
   // only N bits are stored; the shifted trial operand carries the N+1th bit.
   logic [N-1:0]  r_reg;
   logic [N-1:0]  q_reg;
   logic [N-1:0]  dvs_mag;
   logic [N:0]    r_shift;
   logic [N:0]    trial;
   logic          no_borrow;
   logic          unused_trial_msb;

   logic [N-1:0]  dvd_load;
   logic [N-1:0]  dvs_load;
   logic [N-1:0]  q_fix;
   logic [N-1:0]  r_fix;

   assign dvs_zero  = (divisor == '0);
   assign last_iter = (cnt == CW'(N - 1));
   assign r_shift   = {r_reg, q_reg[N-1]};

   div_step #(.W(N + 1)) u_step (
      .minuend    (r_shift),
      .subtrahend ({1'b0, dvs_mag}),
      .diff       (trial),
      .no_borrow  (no_borrow)
   );

   assign unused_trial_msb = trial[N];

`ifdef SEQ_DIVIDER_SIGNED_EN
   logic qneg;
   logic rneg;
   logic dvd_neg;
   logic dvs_neg;

   assign dvd_neg  = is_signed & dividend[N-1];
   assign dvs_neg  = is_signed & divisor[N-1];
   // -(-2^(N-1)) wraps to itself, which is already the correct magnitude.
   assign dvd_load = dvd_neg ? -dividend : dividend;
   assign dvs_load = dvs_neg ? -divisor : divisor;
   assign q_fix    = qneg ? -q_reg : q_reg;
   assign r_fix    = rneg ? -r_reg : r_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         qneg <= 1'b0;
         rneg <= 1'b0;
      end else if (accept) begin
         qneg <= dvd_neg ^ dvs_neg;
         rneg <= dvd_neg;
      end
   end
`else
   logic unused_is_signed;

   assign unused_is_signed = is_signed;
   assign dvd_load = dividend;
   assign dvs_load = divisor;
   assign q_fix    = q_reg;
   assign r_fix    = r_reg;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = dvs_zero ? DONE : RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         RUN: begin
            if (last_iter) begin
               state_nxt = FIXUP;
            end
         end
         FIXUP: begin
            state_nxt = DONE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign busy = (state == RUN) || (state == FIXUP);
   assign done = (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt         <= '0;
         r_reg       <= '0;
         q_reg       <= '0;
         dvs_mag     <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (accept) begin
         cnt         <= '0;
         r_reg       <= '0;
         q_reg       <= dvd_load;
         dvs_mag     <= dvs_load;
         div_by_zero <= dvs_zero;
         if (dvs_zero) begin
            // Zero divisor skips RUN; results are written immediately.
            quotient  <= {N{DIV_ZERO_Q[0]}};
            remainder <= dividend;
         end
      end else if (state == RUN) begin
         r_reg <= no_borrow ? trial[N-1:0] : r_shift[N-1:0];
         q_reg <= {q_reg[N-2:0], no_borrow};
         cnt   <= cnt + CW'(1);
      end else if (state == FIXUP) begin
         quotient  <= q_fix;
         remainder <= r_fix;
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider
module tb_seq_divider;

`ifdef SEQ_DIVIDER_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        is_signed = 1'b0;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   seq_divider #(.N(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .is_signed   (is_signed),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   typedef struct {
      logic        s;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] qs;
      logic [31:0] rs;
      logic [31:0] qu;
      logic [31:0] ru;
      logic        dz;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
      end
   endtask

   // Reference: plain integer division, truncating toward zero when signed.
   function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r, output logic dz);
      int sa;
      int sb;
      dz = (b == 32'd0);
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (SIGNED_EN && s) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 32'd0;
         end else begin
            sa = $signed(a);
            sb = $signed(b);
            q = 32'(sa / sb);
            r = 32'(sa % sb);
         end
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   // Entered and left on a falling edge. poke_at > 0 pulses start (with
   // different operands) in that cycle of the division, which must be ignored.
   task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input int poke_at,
                         output logic [31:0] q, output logic [31:0] r, output logic dz,
                         output int lat, output int bc);
      is_signed = s;
      dividend  = a;
      divisor   = b;
      start     = 1'b1;
      lat = 0;
      bc  = 0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk);
         lat++;
         #1;
         start = (lat == poke_at);
         if (lat == poke_at) begin
            divisor   = 32'd0;
            dividend  = 32'hDEAD;
            is_signed = ~s;
         end
         @(negedge clk);
         if (busy) bc++;
         if (done) break;
      end
      start = 1'b0;
      q  = quotient;
      r  = remainder;
      dz = div_by_zero;
   endtask

   initial begin
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
      logic [31:0] eq;
      logic [31:0] er;
      logic        edz;
      int          lat;
      int          bc;
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rs;

      vecs[0] = '{1'b0, 32'd100,        32'd7,        32'd14,        32'd2,        32'd14,        32'd2,        1'b0};
      vecs[1] = '{1'b1, 32'hFFFF_FF9C,  32'd7,        32'hFFFF_FFF2, 32'hFFFF_FFFE, 32'h2492_4916, 32'd2,        1'b0};
      vecs[2] = '{1'b1, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2,        32'd0,         32'd100,      1'b0};
      vecs[3] = '{1'b0, 32'h1234,       32'd0,        32'hFFFF_FFFF, 32'h1234,     32'hFFFF_FFFF, 32'h1234,     1'b1};
      vecs[4] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        32'd0,         32'h8000_0000, 1'b0};
      vecs[5] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 32'd0,        32'h8000_0000, 1'b0};
      vecs[6] = '{1'b0, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF, 32'd0,        32'hFFFF_FFFF, 32'd0,        1'b0};
      vecs[7] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE, 32'd0,        32'hFFFF_FF9C, 1'b0};
      vecs[8] = '{1'b0, 32'd5,          32'd9,        32'd0,         32'd5,        32'd0,         32'd5,        1'b0};
      vecs[9] = '{1'b1, 32'hFFFF_FF9C,  32'd0,        32'hFFFF_FFFF, 32'hFFFF_FF9C, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 1'b1};

      // Reset state.
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_quotient", quotient, 32'd0);
      check("rst_remainder", remainder, 32'd0);
      check("rst_dbz", 32'(div_by_zero), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed vectors, issued back to back.
      for (int i = 0; i < 10; i++) begin
         do_div(vecs[i].s, vecs[i].a, vecs[i].b, 0, q, r, dz, lat, bc);
         eq = (SIGNED_EN && vecs[i].s) ? vecs[i].qs : vecs[i].qu;
         er = (SIGNED_EN && vecs[i].s) ? vecs[i].rs : vecs[i].ru;
         check($sformatf("vec%0d_quotient", i), q, eq);
         check($sformatf("vec%0d_remainder", i), r, er);
         check($sformatf("vec%0d_dbz", i), 32'(dz), 32'(vecs[i].dz));
         check($sformatf("vec%0d_latency", i), 32'(lat), vecs[i].dz ? 32'd1 : 32'd34);
         check($sformatf("vec%0d_busy_cycles", i), 32'(bc), vecs[i].dz ? 32'd0 : 32'd33);
      end

      // done is a single-cycle pulse; results hold afterwards.
      @(negedge clk);
      check("done_pulse", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      check("hold_quotient", quotient, 32'hFFFF_FFFF);
      check("hold_remainder", remainder, 32'hFFFF_FF9C);
      check("hold_dbz", 32'(div_by_zero), 32'd1);

      // start pulsed in cycle 10 of a division is ignored.
      do_div(1'b0, 32'd1000, 32'd3, 10, q, r, dz, lat, bc);
      check("ign_quotient", q, 32'd333);
      check("ign_remainder", r, 32'd1);
      check("ign_dbz", 32'(dz), 32'd0);
      check("ign_latency", 32'(lat), 32'd34);

      // start while done is high is accepted.
      check("b2b_done_high", 32'(done), 32'd1);
      do_div(1'b0, 32'd1000000, 32'd1000, 0, q, r, dz, lat, bc);
      check("b2b_quotient", q, 32'd1000);
      check("b2b_remainder", r, 32'd0);
      check("b2b_latency", 32'(lat), 32'd34);
      check("b2b_busy_cycles", 32'(bc), 32'd33);

      // Reset at iteration 16 discards the division and clears outputs.
      is_signed = 1'b0;
      dividend  = 32'hFFFF_1234;
      divisor   = 32'd3;
      start     = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (16) @(posedge clk);
      @(negedge clk);
      check("mid_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_quotient", quotient, 32'd0);
      check("mid_rst_remainder", remainder, 32'd0);
      check("mid_rst_dbz", 32'(div_by_zero), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      do_div(1'b0, 32'hFFFF_FFFF, 32'd1, 0, q, r, dz, lat, bc);
      check("post_rst_quotient", q, 32'hFFFF_FFFF);
      check("post_rst_remainder", r, 32'd0);
      check("post_rst_latency", 32'(lat), 32'd34);

      // Randomized against the reference model.
      for (int i = 0; i < 150; i++) begin
         rs = 1'($urandom_range(0, 1));
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = 32'($urandom_range(0, 15));
            1:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
            default: rb = $urandom;
         endcase
         model(rs, ra, rb, eq, er, edz);
         do_div(rs, ra, rb, 0, q, r, dz, lat, bc);
         check($sformatf("rnd%0d_quotient", i), q, eq);
         check($sformatf("rnd%0d_remainder", i), r, er);
         check($sformatf("rnd%0d_dbz", i), 32'(dz), 32'(edz));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
